// File: rtl/lsu_ext_mem_if.sv
// rtl/lsu_ext_mem_if.sv - single-outstanding load/store bridge from core LSU to external data memory
//
// Accepts one core access at a time. A legal, aligned request is issued to memory in the same
// cycle it is presented in IDLE. The size/offset is turned into byte enables and lane-replicated
// write data. The core is then stalled until mem_ready_i. On completion the loaded sub-word is
// extracted and sign/zero extended. Misaligned or illegal requests and memory timeouts raise
// access_fault_o for exactly one cycle.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset (all outputs forced low while low)
//   core_req_i            core request (sampled only in IDLE)
//   core_we_i             1=store, 0=load
//   core_size_i           funct3 size code: 0=B 1=H 2=W 4=BU 5=HU, 3/6/7 illegal
//   core_addr_i           byte address
//   core_wd_i             store data, LSBs significant
//   core_rd_o             extended load data, nonzero only in the load-completion cycle
//   core_stall_o          hold core pipeline
//   access_fault_o        one-cycle fault pulse (misaligned, illegal size, timeout)
//   mem_req_o             memory request, single cycle
//   mem_we_o              memory write enable
//   mem_be_o              byte enables
//   mem_addr_o            byte address to memory (core address passed through)
//   mem_wd_o              lane-replicated write data
//   mem_rd_i              memory read data, valid with mem_ready_i
//   mem_ready_i           memory completion

module lsu_ext_mem_if #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        access_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;

  // Request decode
  logic          size_legal;
  logic          misaligned;
  logic          req_ok;
  logic          req_bad;
  logic          timeout_hit;

  // Encoded request and extracted load data
  logic [3:0]    be_enc;
  logic [31:0]   wd_enc;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;

  always_comb begin
    size_legal = 1'b0;
    case (core_size_i)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: size_legal = 1'b1;
      default:                      size_legal = 1'b0;
    endcase
  end

  // H and HU share size[1:0]=01; W is the only legal code with size[1:0]=10.
  assign misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                      ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00));

  assign req_ok      = core_req_i && size_legal && !misaligned;
  assign req_bad     = core_req_i && !(size_legal && !misaligned);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Byte-enable and write-data replication from the live core request.
  always_comb begin
    be_enc = 4'b1111;
    wd_enc = core_wd_i;
    case (core_size_i[1:0])
      2'b00: begin
        be_enc = 4'b0001 << core_addr_i[1:0];
        wd_enc = {4{core_wd_i[7:0]}};
      end
      2'b01: begin
        be_enc = 4'b0011 << core_addr_i[1:0];
        wd_enc = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_enc = 4'b1111;
        wd_enc = core_wd_i;
      end
    endcase
  end

  // Sub-word extraction uses the offset and size captured at issue time.
  assign rd_byte = mem_rd_i[{off_q, 3'b000} +: 8];
  assign rd_half = mem_rd_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    rd_ext = mem_rd_i;
    case (size_q)
      3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    rd_ext = {24'h000000, rd_byte};
      3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      3'd5:    rd_ext = {16'h0000, rd_half};
      default: rd_ext = mem_rd_i;
    endcase
  end

  // State register and access context
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (req_ok) begin
          size_q <= core_size_i;
          off_q  <= core_addr_i[1:0];
          we_q   <= core_we_i;
          cnt_q  <= '0;
        end
      end else if (!mem_ready_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_ok) state_d = ACCESS;
      ACCESS:  if (mem_ready_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is held low while reset is asserted.
  always_comb begin
    core_rd_o      = 32'h0;
    core_stall_o   = 1'b0;
    access_fault_o = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'b0000;
    mem_addr_o     = 32'h0;
    mem_wd_o       = 32'h0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (req_ok) begin
            mem_req_o    = 1'b1;
            mem_we_o     = core_we_i;
            mem_be_o     = be_enc;
            mem_addr_o   = core_addr_i;
            mem_wd_o     = wd_enc;
            core_stall_o = 1'b1;
          end else if (req_bad) begin
            access_fault_o = 1'b1;
          end
        end
        ACCESS: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (mem_ready_i) begin
            if (!we_q) core_rd_o = rd_ext;
          end else if (timeout_hit) begin
            access_fault_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ext_mem_if.sv
// tb/tb_lsu_ext_mem_if.sv - directed vector bench for lsu_ext_mem_if
module tb_lsu_ext_mem_if;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        access_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int total = 0;
  int bad   = 0;

  lsu_ext_mem_if #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .access_fault_o(access_fault_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mrd;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a request and wait to mid-cycle for sampling.
  task automatic drive_req(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    #3;
  endtask

  task automatic idle_inputs();
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_ready_i = 1'b0;
    mem_rd_i    = 32'h0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vt[1]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vt[2]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h0,        32'h00000080};
    vt[3]  = '{1'b0, 3'd1, 32'h22, 32'h0,        32'h80017FFF, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
    vt[4]  = '{1'b0, 3'd5, 32'h20, 32'h0,        32'h8001F00D, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
    vt[5]  = '{1'b1, 3'd1, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    vt[6]  = '{1'b1, 3'd0, 32'h21, 32'h0000005A, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h5A5A5A5A, 32'h0};
    vt[7]  = '{1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[8]  = '{1'b0, 3'd2, 32'h02, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vt[9]  = '{1'b0, 3'd3, 32'h00, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vt[10] = '{1'b0, 3'd5, 32'h21, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
    vt[11] = '{1'b1, 3'd7, 32'h00, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

    idle_inputs();
    rst_ni = 1'b0;
    cyc();
    cyc();
    // Outputs forced low during reset even with a request present.
    drive_req(1'b0, 3'd2, 32'h10, 32'h0);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
    chk("rst_fault", {31'h0, access_fault_o}, 32'h0);
    chk("rst_be", {28'h0, mem_be_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    cyc();
    idle_inputs();
    rst_ni = 1'b1;
    #3;
    chk("idle_stall", {31'h0, core_stall_o}, 32'h0);
    chk("idle_rd", core_rd_o, 32'h0);
    cyc();

    // Table-driven single accesses with ready the cycle after issue.
    for (int i = 0; i < 12; i++) begin
      drive_req(vt[i].we, vt[i].size, vt[i].addr, vt[i].wd);
      if (vt[i].flt) begin
        chk($sformatf("v%0d_req", i), {31'h0, mem_req_o}, 32'h0);
        chk($sformatf("v%0d_stall", i), {31'h0, core_stall_o}, 32'h0);
        chk($sformatf("v%0d_fault", i), {31'h0, access_fault_o}, 32'h1);
      end else begin
        chk($sformatf("v%0d_req", i), {31'h0, mem_req_o}, 32'h1);
        chk($sformatf("v%0d_stall0", i), {31'h0, core_stall_o}, 32'h1);
        chk($sformatf("v%0d_we", i), {31'h0, mem_we_o}, {31'h0, vt[i].we});
        chk($sformatf("v%0d_be", i), {28'h0, mem_be_o}, {28'h0, vt[i].be});
        chk($sformatf("v%0d_addr", i), mem_addr_o, vt[i].addr);
        if (vt[i].we) chk($sformatf("v%0d_wd", i), mem_wd_o, vt[i].ewd);
        chk($sformatf("v%0d_rd0", i), core_rd_o, 32'h0);
      end
      cyc();
      idle_inputs();
      mem_ready_i = 1'b1;
      mem_rd_i    = vt[i].mrd;
      #3;
      chk($sformatf("v%0d_stall1", i), {31'h0, core_stall_o}, 32'h0);
      chk($sformatf("v%0d_fault1", i), {31'h0, access_fault_o}, 32'h0);
      chk($sformatf("v%0d_rd1", i), core_rd_o, vt[i].flt ? 32'h0 : vt[i].erd);
      chk($sformatf("v%0d_req1", i), {31'h0, mem_req_o}, 32'h0);
      cyc();
      idle_inputs();
    end

    // Slow memory: four not-ready access cycles, then data.
    drive_req(1'b0, 3'd2, 32'h50, 32'h0);
    chk("slow_stall0", {31'h0, core_stall_o}, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      idle_inputs();
      mem_ready_i = (k == 5);
      mem_rd_i    = 32'h12345678;
      #3;
      chk($sformatf("slow_stall%0d", k), {31'h0, core_stall_o}, (k == 5) ? 32'h0 : 32'h1);
      chk($sformatf("slow_rd%0d", k), core_rd_o, (k == 5) ? 32'h12345678 : 32'h0);
    end
    cyc();
    idle_inputs();

    // No ready: fault exactly 16 cycles after the request cycle.
    drive_req(1'b0, 3'd2, 32'h60, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      idle_inputs();
      mem_rd_i = 32'hFFFFFFFF;
      #3;
      chk($sformatf("to_stall%0d", k), {31'h0, core_stall_o}, (k == 16) ? 32'h0 : 32'h1);
      chk($sformatf("to_fault%0d", k), {31'h0, access_fault_o}, (k == 16) ? 32'h1 : 32'h0);
    end
    chk("to_rd", core_rd_o, 32'h0);
    cyc();
    idle_inputs();
    #3;
    chk("to_after_fault", {31'h0, access_fault_o}, 32'h0);
    cyc();

    // Ready coincides with the timeout cycle: ready wins.
    drive_req(1'b0, 3'd4, 32'h71, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      idle_inputs();
      mem_ready_i = (k == 16);
      mem_rd_i    = 32'h0000C300;
      #3;
    end
    chk("race_fault", {31'h0, access_fault_o}, 32'h0);
    chk("race_rd", core_rd_o, 32'h000000C3);
    chk("race_stall", {31'h0, core_stall_o}, 32'h0);
    cyc();
    idle_inputs();

    // Reset while in ACCESS abandons the access without a fault.
    drive_req(1'b0, 3'd2, 32'h80, 32'h0);
    cyc();
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    chk("mrst_stall", {31'h0, core_stall_o}, 32'h0);
    chk("mrst_fault", {31'h0, access_fault_o}, 32'h0);
    cyc();
    rst_ni = 1'b1;
    #3;
    chk("mrst_idle_stall", {31'h0, core_stall_o}, 32'h0);
    chk("mrst_idle_fault", {31'h0, access_fault_o}, 32'h0);
    cyc();
    drive_req(1'b0, 3'd2, 32'h90, 32'h0);
    chk("post_rst_req", {31'h0, mem_req_o}, 32'h1);
    cyc();
    idle_inputs();
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hA5A5A5A5;
    #3;
    chk("post_rst_rd", core_rd_o, 32'hA5A5A5A5);
    chk("post_rst_stall", {31'h0, core_stall_o}, 32'h0);
    cyc();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ext_mem_if.md
Name: lsu_ext_mem_if

Overview:
Load-store unit sitting between the core's LSU port and the external data memory. It accepts one core load/store at a time and encodes size/offset into byte enables and replicated write data. It stalls the core until memory signals ready, then extracts and sign/zero-extends the loaded sub-word. Misaligned accesses, illegal size codes and memory timeouts are reported as a one-cycle fault pulse.

Parameters:
TIMEOUT_CYCLES, 16, maximum ACCESS cycles without mem_ready_i before the access is aborted (>=1).

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
core_req_i  input  1  core memory request
core_we_i  input  1  1=store, 0=load
core_size_i  input  3  funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU; 3/6/7 illegal
core_addr_i  input  32  byte address
core_wd_i  input  32  store data (LSBs significant)
core_rd_o  output  32  extended load data
core_stall_o  output  1  hold core pipeline
access_fault_o  output  1  one-cycle fault pulse
mem_req_o  output  1  memory request
mem_we_o  output  1  memory write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  32  byte address to memory (unmodified core_addr_i)
mem_wd_o  output  32  replicated write data
mem_rd_i  input  32  memory read data (valid when mem_ready_i)
mem_ready_i  input  1  memory completion

Behaviour:
- States IDLE, ACCESS. Registers: state, size_q[2:0], off_q[1:0], we_q, timeout counter cnt (width $clog2(TIMEOUT_CYCLES+1)).
- Reset (rst_ni=0 at clk edge): state=IDLE, cnt=0, size_q=0, off_q=0, we_q=0. While rst_ni=0, all outputs are 0. Reset during ACCESS abandons the access; no fault pulse.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: size 3/6/7.
- IDLE, core_req_i=1, legal and aligned: mem_req_o=1, mem_we_o=core_we_i, mem_addr_o=core_addr_i, core_stall_o=1. Capture size, addr[1:0] and we. Next state ACCESS, cnt=0.
- IDLE, core_req_i=1, misaligned or illegal: mem_req_o=0, core_stall_o=0, access_fault_o=1 for that cycle, stay IDLE.
- IDLE, core_req_i=0: all mem_* and core_* outputs 0. mem_ready_i is ignored.
- Encoding (IDLE request cycle):
  - B/BU: be=4'b0001<<off, wd={4{wd[7:0]}}.
  - H/HU: be=4'b0011<<off, wd={2{wd[15:0]}}.
  - W: be=4'b1111, wd=wd.
  - Loads drive the same be.
- ACCESS: mem_req_o=0, core_req_i and core_* inputs ignored.
  - mem_ready_i=1: core_stall_o=0; if !we_q, core_rd_o=extract(mem_rd_i); next IDLE.
  - mem_ready_i=0: core_stall_o=1, cnt++.
  - mem_ready_i=0 with cnt==TIMEOUT_CYCLES-1: core_stall_o=0, access_fault_o=1, core_rd_o=0, next IDLE.
  - mem_ready_i and timeout in the same cycle: ready wins, no fault.
- Extract: byte = mem_rd_i[8*off_q+:8]; half = mem_rd_i[16*off_q[1]+:16].
  - B sign-extends byte; BU zero-extends byte.
  - H sign-extends half; HU zero-extends half.
  - W passes the word.
- core_rd_o=0 in every cycle other than the ACCESS load-completion cycle.
- Minimum latency with ready-next-cycle memory: request cycle stalled, completion the following cycle (2 cycles per access). A back-to-back request is accepted in the cycle after completion.

Test Plan:
- Word load: addr=0x10, size=2, mem_rd_i=0xDEADBEEF with ready next cycle -> cycle0 stall=1, mem_be=4'b1111; cycle1 stall=0, core_rd_o=0xDEADBEEF.
- Byte loads: addr=0x13, mem_rd_i=0x80112233 -> size 0 gives 0xFFFFFF80; size 4 gives 0x00000080; mem_be=4'b1000.
- Stores: half at addr=0x22, wd=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wd=0xABCDABCD, one-cycle stall. Byte at addr=0x21, wd=0x5A -> mem_be=4'b0010, mem_wd=0x5A5A5A5A.
- Faults: W at addr=0x02, then size=3 at addr=0x00 -> each gives mem_req_o=0, stall=0, access_fault_o=1 for one cycle, state stays IDLE.
- Slow memory: ready after 5 cycles with TIMEOUT_CYCLES=16 -> stall for 5 cycles, then data. No ready at all -> fault pulse exactly 16 cycles after the request cycle, stall drops.
- Reset mid-access: assert rst_ni=0 while in ACCESS -> next cycle IDLE, all outputs 0, no fault. A new request after release completes normally.
